shift_load_sequencer: RTL and testbench

Upstream controller for the 4-bit parallel-access shift register (`shift4`). It accepts a parallel word through a start/ready handshake and drives the register's `R`, `L` and `w` inputs. The sequence is one load cycle, then exactly N right-shift cycles, then a one-cycle `Done` pulse. The register's own `Q` stays connected directly to consumers; this block only sequences it.

---
 rtl/shift_load_sequencer.sv | 150 +++++++++++++++
 tb/tb_shift_load_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shift_load_sequencer.sv
// -----------------------------------------------------------------------------
// shift_load_sequencer
//
// Upstream controller for a 4-bit (generally N-bit) parallel-access shift
// register. A word is accepted through a Start/Ready handshake, then the
// block drives one load cycle (L=1, R=word), exactly N right-shift cycles
// (L=0, w=fill bit), and a single-cycle Done pulse while the register shows
// the fully shifted word.
//
// Handshake: an accept happens on a rising Clock edge where Start && Ready.
// Ready is a registered output, so the decision never depends combinationally
// on Start. Start while Ready=0 is ignored (not queued, data not sampled).
//
// Optional feature (macro SHIFT_SEQ_BACK_TO_BACK_EN):
//   defined   - Ready=1 in DONE; an accept in DONE goes straight to LOAD.
//   undefined - Ready=0 in DONE; DONE always returns to IDLE.
//
// Ports:
//   Clock     in   1   rising-edge clock (shared with the shift register)
//   Reset     in   1   synchronous, active-high
//   DataIn    in   N   word to load, sampled on accept
//   FillIn    in   1   serial fill bit for the shift phase, sampled on accept
//   Start     in   1   request to send DataIn
//   Ready     out  1   sequencer can accept
//   R         out  N   parallel load value to the shift register
//   L         out  1   load enable (1 = load, 0 = shift)
//   w         out  1   serial input to the shift register
//   Done      out  1   one-cycle pulse, register holds the shifted word
//   StateDbg  out  2   current FSM state (0=IDLE 1=LOAD 2=SHIFT 3=DONE)
// -----------------------------------------------------------------------------
module shift_load_sequencer #(
    parameter int N = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] DataIn,
    input  logic         FillIn,
    input  logic         Start,
    output logic         Ready,
    output logic [N-1:0] R,
    output logic         L,
    output logic         w,
    output logic         Done,
    output logic [1:0]   StateDbg
);

    localparam int CNT_W = $clog2(N) + 1;

`ifdef SHIFT_SEQ_BACK_TO_BACK_EN
    localparam logic B2B = 1'b1;
`else
    localparam logic B2B = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       hold_q, hold_d;
    logic               fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               l_q, l_d;
    logic               w_q, w_d;
    logic               done_q, done_d;
    logic               accept;

    // ready_q is the value the outside world sees, so accept uses it directly.
    assign accept = Start && ready_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    hold_d  = DataIn;
                    fill_d  = FillIn;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Counter saturates at N-1; this is the last of N shift cycles.
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (accept) begin
                    hold_d  = DataIn;
                    fill_d  = FillIn;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so every
        // output is a pure function of registered state in its own cycle.
        ready_d = (state_d == IDLE) || (B2B && (state_d == DONE));
        l_d     = (state_d == LOAD);
        w_d     = (state_d == SHIFT) && fill_d;
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            fill_q  <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            l_q     <= 1'b0;
            w_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            l_q     <= l_d;
            w_q     <= w_d;
            done_q  <= done_d;
        end
    end

    assign Ready    = ready_q;
    assign R        = hold_q;
    assign L        = l_q;
    assign w        = w_q;
    assign Done     = done_q;
    assign StateDbg = state_q;

endmodule

// File: tb/tb_shift_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_load_sequencer
//
// Drives the sequencer with directed and random traffic and compares every
// cycle against a transaction-level model: each accepted word is tracked by
// its age in cycles since acceptance, from which the expected L/w/Done/Ready
// follow directly from the timing rules. A behavioural shift4 register is
// fed by the DUT outputs to confirm the loaded and fully shifted words.
// -----------------------------------------------------------------------------
module tb_shift_load_sequencer;

  localparam int N = 4;

`ifdef SHIFT_SEQ_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         Clock = 1'b0;
  logic         Reset;
  logic [N-1:0] DataIn;
  logic         FillIn;
  logic         Start;
  logic         Ready;
  logic [N-1:0] R;
  logic         L;
  logic         w;
  logic         Done;
  logic [1:0]   StateDbg;

  always #5 Clock = ~Clock;

  shift_load_sequencer #(.N(N)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .DataIn   (DataIn),
    .FillIn   (FillIn),
    .Start    (Start),
    .Ready    (Ready),
    .R        (R),
    .L        (L),
    .w        (w),
    .Done     (Done),
    .StateDbg (StateDbg)
  );

  // ---------------- scoreboard / model state ----------------
  int           errors = 0;
  int           checks = 0;
  int           cyc    = 0;
  int           age    = 0;     // 0 = idle, 1 = load, 2..N+1 = shift, N+2 = done
  logic [N-1:0] held   = '0;
  logic         hfill  = 1'b0;
  logic [N-1:0] q_m    = '0;    // behavioural shift4 fed by DUT outputs
  int           l_cycles[$];
  logic [N-1:0] exp_q[$];       // words expected to appear on R at load

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic rst, input logic st, input logic [N-1:0] din, input logic fin);
    logic         pre_l;
    logic [N-1:0] pre_r;
    logic         pre_w;
    logic         m_ready;
    logic [N-1:0] all_fill;
    @(negedge Clock);
    Reset  = rst;
    Start  = st;
    DataIn = din;
    FillIn = fin;
    pre_l  = L;
    pre_r  = R;
    pre_w  = w;
    @(posedge Clock);
    #1;
    cyc++;

    // shift register reacts to what the sequencer presented before the edge
    if (pre_l) q_m = pre_r;
    else       q_m = {pre_w, q_m[N-1:1]};

    if (rst) begin
      age   = 0;
      held  = '0;
      hfill = 1'b0;
      exp_q.delete();
    end else begin
      m_ready = (age == 0) || (B2B && age == N + 2);
      if (st && m_ready) begin
        age   = 1;
        held  = din;
        hfill = fin;
        exp_q.push_back(din);
      end else if (age == 0 || age == N + 2) begin
        age = 0;
      end else begin
        age++;
      end
    end

    check_eq("ready", Ready, (age == 0) || (B2B && age == N + 2));
    check_eq("L", L, age == 1);
    check_eq("w", w, (age >= 2 && age <= N + 1) ? hfill : 1'b0);
    check_eq("done", Done, age == N + 2);
    if (age == 0 || age == 1) check_eq("R", R, held);
    if (L) l_cycles.push_back(cyc);
    if (age == 1) begin
      if (exp_q.size() > 0) begin
        check_eq("load_word", R, exp_q.pop_front());
      end else begin
        check_eq("load_word_queue_empty", 1, 0);
      end
    end
    if (age == 2) check_eq("q_loaded", q_m, held);
    if (age == N + 2) begin
      all_fill = {N{hfill}};
      check_eq("q_final", q_m, all_fill);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    Reset  = 1'b1;
    Start  = 1'b0;
    DataIn = '0;
    FillIn = 1'b0;

    cycle(1, 0, '0, 0);
    cycle(1, 1, 4'b1111, 1);          // Start during reset is ignored
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 0);
    check_eq("reset_R", R, 0);

    // 1010, fill 0
    cycle(0, 1, 4'b1010, 0);
    for (int i = 0; i < N + 3; i++) cycle(0, 0, 4'b0000, 0);

    // 1001, fill 1
    cycle(0, 1, 4'b1001, 1);
    for (int i = 0; i < N + 3; i++) cycle(0, 0, 4'b0000, 0);

    // Start held with changing data: captured word must stay on R
    l_cycles.delete();
    for (int i = 0; i < 2 * (N + 3); i++) cycle(0, 1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    cycle(0, 0, '0, 0);
    if (l_cycles.size() >= 2) begin
      gap = l_cycles[1] - l_cycles[0];
      check_eq("l_gap", gap, B2B ? N + 2 : N + 3);
    end else begin
      check_eq("l_pulse_count", l_cycles.size(), 2);
    end
    for (int i = 0; i < N + 3; i++) cycle(0, 0, '0, 0);

    // Reset during the second SHIFT cycle aborts the word
    cycle(0, 1, 4'b0110, 1);
    cycle(0, 0, '0, 0);               // LOAD
    cycle(0, 0, '0, 0);               // SHIFT 1
    cycle(1, 0, '0, 0);               // reset edge during SHIFT 2
    check_eq("abort_R", R, 0);
    for (int i = 0; i < N + 3; i++) cycle(0, 0, '0, 0);

    // back-to-back style: 0011 then 0110 with Start held
    l_cycles.delete();
    cycle(0, 1, 4'b0011, 0);
    for (int i = 0; i < N + 1; i++) cycle(0, 1, 4'b0011, 0);
    for (int i = 0; i < 2; i++) cycle(0, 1, 4'b0110, 0);
    for (int i = 0; i < N + 3; i++) cycle(0, 0, '0, 0);
    if (l_cycles.size() >= 2) begin
      check_eq("b2b_gap", l_cycles[1] - l_cycles[0], B2B ? N + 2 : N + 3);
    end else begin
      check_eq("b2b_pulse_count", l_cycles.size(), 2);
    end

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < N + 3; i++) cycle(0, 0, '0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
